// File: rtl/regfile_dump_reader_if.sv
// Output stream of the register-file dump reader: one captured word plus its binary index,
// moved on a valid/ready handshake.
interface regfile_dump_reader_if #(
    parameter int K    = 16,
    parameter int IDXW = 3
);
    logic            out_valid;
    logic            out_ready;
    logic [K-1:0]    out_data;
    logic [IDXW-1:0] out_index;

    modport master (output out_valid, out_data, out_index, input out_ready);
    modport slave  (input out_valid, out_data, out_index, output out_ready);
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks every register of the file through its one-hot read mux and streams each word out.
// Optional REGFILE_DUMP_CHECKSUM_EN adds a running XOR of the words captured since the last start.
module regfile_dump_reader #(
    parameter int k     = 16,
    parameter int NREGS = 8,
    parameter int IDXW  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [NREGS-1:0]      rd_select,
    input  logic [k-1:0]          rd_data,
    regfile_dump_reader_if.master out,
    output logic                  busy,
    output logic                  done
`ifdef REGFILE_DUMP_CHECKSUM_EN
    ,
    output logic [k-1:0]          checksum
`endif
);

    if (NREGS != (1 << IDXW) || NREGS < 2 || NREGS > 256) begin : g_bad_cfg
        $error("regfile_dump_reader: NREGS must be a power of two in 2..256 equal to 2**IDXW");
    end

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_OUTPUT, S_DONE} state_t;

    state_t          r_state;
    logic [IDXW-1:0] r_idx;
    logic            r_valid;
    logic [k-1:0]    r_data;
    logic [IDXW-1:0] r_index;
    logic            r_busy;
    logic            r_done;
    logic            w_last;

    assign w_last = (r_idx == IDXW'(NREGS - 1));

    // The read mux is shared with the register file, so select only while capturing.
    assign rd_select = (r_state == S_SELECT) ? (NREGS'(1) << r_idx) : '0;

    assign out.out_valid = r_valid;
    assign out.out_data  = r_data;
    assign out.out_index = r_index;
    assign busy          = r_busy;
    assign done          = r_done;

`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [k-1:0] r_cks;
    assign checksum = r_cks;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_index <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            r_cks   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SELECT;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        r_cks   <= '0;
`endif
                    end
                end
                S_SELECT: begin
                    r_data  <= rd_data;
                    r_index <= r_idx;
                    r_valid <= 1'b1;
                    r_state <= S_OUTPUT;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    r_cks   <= r_cks ^ rd_data;
`endif
                end
                S_OUTPUT: begin
                    // Word stays put until the consumer takes it.
                    if (out.out_ready) begin
                        r_valid <= 1'b0;
                        if (w_last) begin
                            r_idx   <= '0;
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_SELECT;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: a register-file model feeds the read mux, every
// dump pushes its expected words, and a negedge monitor pops and compares handshakes.
module tb_regfile_dump_reader;

    localparam int K = 16;
    localparam int N = 8;
    localparam int W = 3;

    typedef struct {
        logic [W-1:0] idx;
        logic [K-1:0] data;
    } item_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] rd_select;
    logic [K-1:0] rd_data;
    logic         busy, done;
    logic [K-1:0] regs [N];
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [K-1:0] checksum;
`endif

    regfile_dump_reader_if #(.K(K), .IDXW(W)) dif ();

    regfile_dump_reader #(.k(K), .NREGS(N), .IDXW(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rd_select(rd_select), .rd_data(rd_data),
        .out(dif), .busy(busy), .done(done)
`ifdef REGFILE_DUMP_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    // Register file read mux: OR of the selected words, so a multi-hot select would corrupt data.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N; i++)
            if (rd_select[i]) rd_data = rd_data | regs[i];
    end

    item_t        sb[$];
    int           checks = 0, failures = 0;
    int           edge_cnt = 0, done_cnt = 0, done_edge = 0, words_cnt = 0, n_idx3 = 0;
    int           ready_mode = 0, bp_cnt = 0;
    logic [K-1:0] exp_cks = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) edge_cnt++;

    // Consumer: always ready, randomly ready, or a 5-cycle stall on index 3.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: dif.out_ready = 1'b1;
            1: dif.out_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (dif.out_valid && dif.out_index == 3'd3 && bp_cnt < 5) begin
                    dif.out_ready = 1'b0;
                    bp_cnt++;
                end else dif.out_ready = 1'b1;
            end
        endcase
    end

    // Monitor
    logic         prev_stall = 1'b0;
    logic [K-1:0] pd;
    logic [W-1:0] pi;
    item_t        it;
    always @(negedge clk) begin
        if (reset) prev_stall = 1'b0;
        else begin
            chk("rd_sel_onehot0", 32'($onehot0(rd_select)), 1);
            if (rd_select != '0) begin
                if (sb.size() == 0) chk("rd_sel_unexpected", 32'(rd_select), 0);
                else chk("rd_sel_idx", 32'(rd_select), 32'd1 << sb[0].idx);
                chk("sel_valid_low", 32'(dif.out_valid), 0);
                chk("sel_busy", 32'(busy), 1);
            end
            if (dif.out_valid) begin
                chk("out_rd_sel_zero", 32'(rd_select), 0);
                if (prev_stall) begin
                    chk("hold_data", 32'(dif.out_data), 32'(pd));
                    chk("hold_index", 32'(dif.out_index), 32'(pi));
                end
                if (dif.out_index == 3'd3) n_idx3++;
                if (dif.out_ready) begin
                    if (sb.size() == 0) chk("extra_word", 32'(dif.out_index), 32'hFFFF_FFFF);
                    else begin
                        it = sb.pop_front();
                        chk("word_index", 32'(dif.out_index), 32'(it.idx));
                        chk("word_data", 32'(dif.out_data), 32'(it.data));
                    end
                    words_cnt++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    pd = dif.out_data;
                    pi = dif.out_index;
                end
            end else begin
                if (prev_stall) chk("hold_valid", 32'(dif.out_valid), 1);
                prev_stall = 1'b0;
            end
            if (done) begin
                done_cnt++;
                done_edge = edge_cnt;
                chk("done_all_words", 32'(sb.size()), 0);
                chk("done_busy", 32'(busy), 1);
`ifdef REGFILE_DUMP_CHECKSUM_EN
                chk("done_checksum", 32'(checksum), 32'(exp_cks));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_regs(input int kind);
        for (int i = 0; i < N; i++)
            case (kind)
                0: regs[i] = K'(16'h1111 * i);
                1: regs[i] = K'(1 << i);
                default: regs[i] = K'($urandom);
            endcase
    endtask

    // Expected dump: every register in index order; checksum is the XOR of them all.
    task automatic start_dump(output int t_start);
        exp_cks = '0;
        for (int i = 0; i < N; i++) begin
            sb.push_back('{idx: W'(i), data: regs[i]});
            exp_cks ^= regs[i];
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        t_start = edge_cnt;
    endtask

    task automatic wait_done();
        int old = done_cnt;
        int n = 0;
        while (done_cnt == old && n < 400) begin
            tick();
            n++;
        end
        if (done_cnt == old) chk("done_timeout", 0, 1);
        repeat (3) tick();
        chk("done_once", 32'(done_cnt - old), 1);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_sb_empty", 32'(sb.size()), 0);
    endtask

    task automatic wait_index(input logic [W-1:0] idx);
        int n = 0;
        while (!(dif.out_valid && dif.out_index == idx) && n < 200) begin
            tick();
            n++;
        end
        chk("wait_index_seen", 32'(dif.out_valid && dif.out_index == idx), 1);
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk({nm, "_rd_select"}, 32'(rd_select), 0);
        chk({nm, "_valid"}, 32'(dif.out_valid), 0);
        chk({nm, "_data"}, 32'(dif.out_data), 0);
        chk({nm, "_index"}, 32'(dif.out_index), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_done"}, 32'(done), 0);
`ifdef REGFILE_DUMP_CHECKSUM_EN
        chk({nm, "_checksum"}, 32'(checksum), 0);
`endif
    endtask

    initial begin
        int t0, w0;
        dif.out_ready = 1'b1;
        load_regs(0);
        repeat (3) tick();
        chk_zero_outputs("reset");
        reset = 1'b0;
        tick();

        // Full dump with a permanently ready consumer: done after 2*N edges past the start edge.
        ready_mode = 0;
        start_dump(t0);
        wait_done();
        chk("done_latency", 32'(done_edge - t0), 32'(2 * N));

        // Backpressure on index 3: 5 stalled cycles plus the accepting one.
        ready_mode = 2;
        bp_cnt = 0;
        n_idx3 = 0;
        start_dump(t0);
        wait_done();
        chk("bp_idx3_cycles", 32'(n_idx3), 6);

        // Start pulse while busy is ignored.
        ready_mode = 1;
        load_regs(2);
        w0 = words_cnt;
        start_dump(t0);
        wait_index(3'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        chk("busy_start_words", 32'(words_cnt - w0), 32'(N));

        // Reset during the third word, then a clean dump from index 0.
        load_regs(0);
        start_dump(t0);
        wait_index(3'd2);
        reset = 1'b1;
        sb.delete();
        tick();
        chk_zero_outputs("midreset");
        reset = 1'b0;
        tick();
        load_regs(2);
        start_dump(t0);
        wait_done();

        // Walking-one registers XOR to 00FF, twice in a row.
        ready_mode = 0;
        load_regs(1);
        for (int r = 0; r < 2; r++) begin
            start_dump(t0);
            wait_done();
`ifdef REGFILE_DUMP_CHECKSUM_EN
            chk("checksum_walk1", 32'(checksum), 32'h00FF);
`endif
        end

        // Random contents with a randomly stalling consumer.
        ready_mode = 1;
        for (int r = 0; r < 6; r++) begin
            load_regs(2);
            start_dump(t0);
            wait_done();
`ifdef REGFILE_DUMP_CHECKSUM_EN
            chk("checksum_hold_idle", 32'(checksum), 32'(exp_cks));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
